// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - state_t         : controller states (IDLE, LOOKUP, MISS, DROP)
//   - DEF_INDEX_BITS  : default log2 of the line count
//   - pc_index/pc_tag : split a word-aligned PC into line index and tag.
//                       pc[1:0] never reaches either field.
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int DEF_INDEX_BITS = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        DROP   = 2'd3
    } state_t;

    // Line index = pc[index_bits+1:2], returned zero-extended; callers
    // truncate it to their own index width.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_bits);
        return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    // Tag = pc[31:index_bits+2], returned right-aligned.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
// Storage for the direct-mapped cache: valid vector, tag RAM, data RAM.
//   clk_in, rst_in   : clock, async active-low reset (valid vector only)
//   rd_index         : read index; rd_valid/rd_tag/rd_data are combinational
//   we, wr_index,
//   wr_tag, wr_data  : single write port, writes on the rising edge
//   invalidate_all   : clears every valid bit on the next edge
// The tag and data RAMs carry no reset; a line is only ever trusted through
// its valid bit.
// ---------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [INDEX_BITS-1:0]  rd_index,
    output logic                   rd_valid,
    output logic [29-INDEX_BITS:0] rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   we,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [29-INDEX_BITS:0] wr_tag,
    input  logic [31:0]            wr_data,
    input  logic                   invalidate_all
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Invalidate outranks a same-cycle fill so a fence.i landing on a fill
    // leaves the line invalid.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid <= '0;
        end else if (invalidate_all) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data are still written under invalidate; the cleared valid
    // bit hides them.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller's instruction port.
//   clk_in, rst_in           : clock, async active-low reset
//   rdy_in                   : global ready; low freezes every register
//   fetch_req, fetch_pc      : fetch request (taken only in IDLE)
//   icache_busy              : high whenever the controller is not IDLE
//   inst_ready, inst         : one-cycle response pulse, inst held between pulses
//   flush                    : branch redirect, cancels the pending response
//   invalidate               : fence.i, clears every valid bit
//   mem_need_inst, mem_pc    : word request to memory, held until completion
//   mem_inst_ready, mem_inst : memory word-complete pulse and data
// Hit latency is two cycles: request sampled into LOOKUP, then the tag
// compare registers the response. A miss parks in MISS (or DROP once
// flushed) until memory answers; the line is always filled because the
// transfer cannot be aborted.
// ---------------------------------------------------------------------------
module icache_direct
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        icache_busy,
    output logic        inst_ready,
    output logic [31:0] inst,
    input  logic        flush,
    input  logic        invalidate,
    output logic        mem_need_inst,
    output logic [31:0] mem_pc,
    input  logic        mem_inst_ready,
    input  logic [31:0] mem_inst
);

    localparam int TAG_BITS = 30 - INDEX_BITS;

    state_t              state;
    logic [31:0]         req_pc;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  arr_valid;
    logic [TAG_BITS-1:0]   arr_tag;
    logic [31:0]           arr_data;
    logic                  hit;
    logic                  fill;

    assign req_index = INDEX_BITS'(pc_index(req_pc, INDEX_BITS));
    assign req_tag   = TAG_BITS'(pc_tag(req_pc, INDEX_BITS));
    assign hit       = arr_valid && (arr_tag == req_tag);

    // Both MISS and DROP fill the line when memory answers; DROP only
    // withholds the response.
    assign fill = rdy_in && mem_inst_ready && ((state == MISS) || (state == DROP));

    icache_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rd_index       (req_index),
        .rd_valid       (arr_valid),
        .rd_tag         (arr_tag),
        .rd_data        (arr_data),
        .we             (fill),
        .wr_index       (req_index),
        .wr_tag         (req_tag),
        .wr_data        (mem_inst),
        .invalidate_all (invalidate && rdy_in)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            req_pc        <= '0;
            icache_busy   <= 1'b0;
            inst_ready    <= 1'b0;
            inst          <= '0;
            mem_need_inst <= 1'b0;
            mem_pc        <= '0;
        end else if (rdy_in) begin
            // Response is a single-cycle pulse; every path back to IDLE
            // spends at least one cycle there, so pulses never abut.
            inst_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // A redirect in the same cycle makes the request stale.
                    if (fetch_req && !flush) begin
                        req_pc      <= fetch_pc;
                        state       <= LOOKUP;
                        icache_busy <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (flush) begin
                        state       <= IDLE;
                        icache_busy <= 1'b0;
                    end else if (hit) begin
                        inst        <= arr_data;
                        inst_ready  <= 1'b1;
                        state       <= IDLE;
                        icache_busy <= 1'b0;
                    end else begin
                        mem_need_inst <= 1'b1;
                        mem_pc        <= req_pc;
                        state         <= MISS;
                    end
                end
                MISS: begin
                    if (mem_inst_ready) begin
                        mem_need_inst <= 1'b0;
                        state         <= IDLE;
                        icache_busy   <= 1'b0;
                        // A redirect landing with the data still fills the
                        // line but must not hand the word to the fetcher.
                        if (!flush) begin
                            inst       <= mem_inst;
                            inst_ready <= 1'b1;
                        end
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_inst_ready) begin
                        mem_need_inst <= 1'b0;
                        state         <= IDLE;
                        icache_busy   <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    icache_busy   <= 1'b0;
                    mem_need_inst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
module tb_icache_direct;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic        invalidate = 1'b0;
    logic        mem_inst_ready = 1'b0;
    logic [31:0] mem_inst = '0;
    logic        icache_busy, inst_ready, mem_need_inst;
    logic [31:0] inst, mem_pc;

    icache_direct #(.INDEX_BITS(6)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .fetch_req      (fetch_req),
        .fetch_pc       (fetch_pc),
        .icache_busy    (icache_busy),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .flush          (flush),
        .invalidate     (invalidate),
        .mem_need_inst  (mem_need_inst),
        .mem_pc         (mem_pc),
        .mem_inst_ready (mem_inst_ready),
        .mem_inst       (mem_inst)
    );

    always #5 clk_in = ~clk_in;

    localparam int MEM_DELAY = 5;

    int total = 0;
    int bad   = 0;
    bit mem_auto = 1'b1;
    int mem_cnt  = 0;

    typedef struct {
        logic [31:0] pc;
        bit          miss;
        logic [31:0] word;
        string       name;
    } vec_t;

    vec_t vecs[11];

    // Backing memory: pc 0 holds 0x93, everything else {pc[15:0], 16'h0013}.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h0) return 32'h0000_0093;
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One cycle step; all sampling and driving happens on the falling edge.
    // The auto memory responder answers MEM_DELAY sampled cycles after it
    // sees a request, with a one-cycle ready pulse.
    task automatic tick();
        @(negedge clk_in);
        if (mem_auto && rdy_in) begin
            if (mem_inst_ready) begin
                mem_inst_ready = 1'b0;
            end else if (mem_need_inst) begin
                mem_cnt++;
                if (mem_cnt >= MEM_DELAY) begin
                    mem_inst_ready = 1'b1;
                    mem_inst       = mem_word(mem_pc);
                    mem_cnt        = 0;
                end
            end
        end
    endtask

    task automatic issue(input logic [31:0] pc);
        tick();
        fetch_req = 1'b1;
        fetch_pc  = pc;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic wait_need(input string name);
        int n = 0;
        while (!mem_need_inst && n < 20) begin
            tick();
            n++;
        end
        chk({name, " need"}, mem_need_inst, 1);
    endtask

    task automatic do_fetch(input logic [31:0] pc, input bit exp_miss,
                            input logic [31:0] exp_inst, input string name);
        int lat = 1;
        bit saw_miss = 0, pc_bad = 0, got = 0;
        issue(pc);
        chk({name, " busy"}, icache_busy, 1);
        for (int i = 0; i < 100; i++) begin
            if (mem_need_inst) begin
                saw_miss = 1;
                if (mem_pc !== pc) pc_bad = 1;
            end
            if (inst_ready) begin
                got = 1;
                break;
            end
            tick();
            lat++;
        end
        chk({name, " done"}, got, 1);
        chk({name, " inst"}, inst, exp_inst);
        chk({name, " miss"}, saw_miss, exp_miss);
        if (exp_miss) chk({name, " mem_pc"}, pc_bad, 0);
        else          chk({name, " latency"}, lat, 2);
        tick();
        chk({name, " pulse"}, inst_ready, 0);
        chk({name, " idle"}, icache_busy, 0);
        chk({name, " hold"}, inst, exp_inst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit frozen;

        vecs[0]  = '{32'h0000_0000, 1, 32'h0000_0093, "cold0"};
        vecs[1]  = '{32'h0000_0000, 0, 32'h0000_0093, "hit0"};
        vecs[2]  = '{32'h0000_0100, 1, 32'h0100_0013, "conf100"};
        vecs[3]  = '{32'h0000_0000, 1, 32'h0000_0093, "evict0"};
        vecs[4]  = '{32'h0000_0100, 1, 32'h0100_0013, "evict100"};
        vecs[5]  = '{32'h0000_0004, 1, 32'h0004_0013, "cold4"};
        vecs[6]  = '{32'h0000_0004, 0, 32'h0004_0013, "hit4"};
        vecs[7]  = '{32'h0000_03FC, 1, 32'h03FC_0013, "cold3fc"};
        vecs[8]  = '{32'h8000_00FC, 1, 32'h00FC_0013, "hightag"};
        vecs[9]  = '{32'h0000_03FC, 1, 32'h03FC_0013, "evict3fc"};
        vecs[10] = '{32'h0000_0004, 0, 32'h0004_0013, "rehit4"};

        // Reset values
        repeat (2) @(negedge clk_in);
        chk("rst busy", icache_busy, 0);
        chk("rst inst_ready", inst_ready, 0);
        chk("rst inst", inst, 0);
        chk("rst need", mem_need_inst, 0);
        chk("rst mem_pc", mem_pc, 0);
        rst_in = 1'b1;

        foreach (vecs[i]) do_fetch(vecs[i].pc, vecs[i].miss, vecs[i].word, vecs[i].name);

        // Flush two cycles into a miss: request held, line filled, no response
        issue(32'h0000_0200);
        wait_need("flmiss");
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flmiss held", mem_need_inst, 1);
        chk("flmiss pc", mem_pc, 32'h0000_0200);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (inst_ready) seen = 1;
        end
        chk("flmiss no_rdy", seen, 0);
        chk("flmiss drained", mem_need_inst, 0);
        chk("flmiss idle", icache_busy, 0);
        do_fetch(32'h0000_0200, 0, 32'h0200_0013, "flmiss refetch");

        // Flush during LOOKUP of a resident line: no response
        issue(32'h0000_0004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (inst_ready || mem_need_inst) seen = 1;
            tick();
        end
        chk("fllook quiet", seen, 0);
        chk("fllook idle", icache_busy, 0);

        // Flush coincident with fetch_req in IDLE drops the request
        tick();
        fetch_req = 1'b1;
        fetch_pc  = 32'h0000_0004;
        flush     = 1'b1;
        tick();
        fetch_req = 1'b0;
        flush     = 1'b0;
        chk("flidle busy", icache_busy, 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (inst_ready) seen = 1;
        end
        chk("flidle no_rdy", seen, 0);

        // Invalidate while idle forces a miss on a resident line
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        do_fetch(32'h0000_0004, 1, 32'h0004_0013, "inval");

        // Invalidate coincident with a fill: response kept, line left invalid
        mem_auto = 1'b0;
        issue(32'h0000_0008);
        wait_need("invfill");
        mem_inst_ready = 1'b1;
        mem_inst       = mem_word(32'h0000_0008);
        invalidate     = 1'b1;
        tick();
        mem_inst_ready = 1'b0;
        invalidate     = 1'b0;
        chk("invfill rdy", inst_ready, 1);
        chk("invfill inst", inst, 32'h0008_0013);
        mem_auto = 1'b1;
        do_fetch(32'h0000_0008, 1, 32'h0008_0013, "invfill refetch");

        // Flush coincident with completion: fill happens, response suppressed
        mem_auto = 1'b0;
        issue(32'h0000_000C);
        wait_need("flfill");
        mem_inst_ready = 1'b1;
        mem_inst       = mem_word(32'h0000_000C);
        flush          = 1'b1;
        tick();
        mem_inst_ready = 1'b0;
        flush          = 1'b0;
        chk("flfill no_rdy", inst_ready, 0);
        chk("flfill drained", mem_need_inst, 0);
        chk("flfill inst_kept", inst, 32'h0008_0013);
        mem_auto = 1'b1;
        do_fetch(32'h0000_000C, 0, 32'h000C_0013, "flfill refetch");

        // rdy_in low for 3 cycles during MISS; invalidate then is ignored too
        mem_auto = 1'b0;
        issue(32'h0000_0010);
        wait_need("rdy");
        rdy_in     = 1'b0;
        invalidate = 1'b1;
        frozen     = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!mem_need_inst || mem_pc !== 32'h0000_0010 || !icache_busy || inst_ready)
                frozen = 0;
        end
        chk("rdy frozen", frozen, 1);
        rdy_in         = 1'b1;
        invalidate     = 1'b0;
        mem_inst_ready = 1'b1;
        mem_inst       = mem_word(32'h0000_0010);
        tick();
        mem_inst_ready = 1'b0;
        chk("rdy done", inst_ready, 1);
        chk("rdy inst", inst, 32'h0010_0013);
        mem_auto = 1'b1;
        do_fetch(32'h0000_0010, 0, 32'h0010_0013, "rdy rehit");
        do_fetch(32'h0000_000C, 0, 32'h000C_0013, "rdy inv_ignored");

        // Async reset mid-MISS clears outputs at once and all valid bits
        mem_auto = 1'b0;
        issue(32'h0000_0014);
        wait_need("arst");
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst busy", icache_busy, 0);
        chk("arst need", mem_need_inst, 0);
        chk("arst mem_pc", mem_pc, 0);
        chk("arst inst", inst, 0);
        chk("arst inst_ready", inst_ready, 0);
        tick();
        rst_in   = 1'b1;
        mem_auto = 1'b1;
        do_fetch(32'h0000_0010, 1, 32'h0010_0013, "arst refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
